// File: rtl/mem_arb_pkg.sv
// Shared types for the memory bus arbiter.
// FSM states, grant IDs and default widths.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating grant-time counter with a sticky timeout flag.
// Ports: i_clr restarts the count, i_en advances it, o_err is sticky.
module arb_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_sat;
  logic          w_hit;

  // TIMEOUT of zero leaves the counter pinned and the flag clear.
  assign w_sat = (r_cnt == LIM);
  assign w_hit = (TIMEOUT != 0) && (r_cnt == LIM - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en && !w_sat) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Flag sets on the same edge the count lands on TIMEOUT.
      if (!i_clr && i_en && w_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between I and D refill.
// Ports: I/D request sides, memory command side, busy, timeout_err.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  arb_state_t        r_state;
  arb_state_t        w_state;
  logic              r_last;
  logic              w_last;
  logic              r_mem_read;
  logic              w_mem_read;
  logic              r_mem_write;
  logic              w_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] w_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [DATA_W-1:0] w_d_rdata;
  logic              r_i_ready;
  logic              w_i_ready;
  logic              r_d_ready;
  logic              w_d_ready;
  logic              r_busy;
  logic              w_busy;
  logic              w_any_d;
  logic              w_pick_d;
  logic              w_wd_clr;
  logic              w_wd_en;
  logic              w_in_grant;

  assign w_any_d = d_read | d_write;

  // D wins when alone, or on a conflict when I was served last.
  assign w_pick_d = w_any_d && (!i_req || (r_last == GNT_I));

  assign w_in_grant = (r_state == GRANT_I) || (r_state == GRANT_D);
  assign w_wd_en    = w_in_grant && !mem_ready;

  always_comb begin
    w_state     = r_state;
    w_last      = r_last;
    w_mem_read  = r_mem_read;
    w_mem_write = r_mem_write;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_i_rdata   = r_i_rdata;
    w_d_rdata   = r_d_rdata;
    w_i_ready   = 1'b0;
    w_d_ready   = 1'b0;
    w_wd_clr    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_state     = GRANT_D;
          w_last      = GNT_D;
          // Write-back outranks a simultaneous read.
          w_mem_write = d_write;
          w_mem_read  = !d_write;
          w_mem_addr  = d_addr;
          w_mem_wdata = d_wdata;
          w_wd_clr    = 1'b1;
        end else if (i_req) begin
          w_state     = GRANT_I;
          w_last      = GNT_I;
          w_mem_write = 1'b0;
          w_mem_read  = 1'b1;
          w_mem_addr  = i_addr;
          w_wd_clr    = 1'b1;
        end
      end
      GRANT_I: begin
        if (mem_ready) begin
          w_state     = RESP_I;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          w_i_rdata   = mem_rdata;
          w_i_ready   = 1'b1;
        end
      end
      GRANT_D: begin
        if (mem_ready) begin
          w_state     = RESP_D;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          if (r_mem_read) begin
            w_d_rdata = mem_rdata;
          end
          w_d_ready   = 1'b1;
        end
      end
      RESP_I: w_state = IDLE;
      RESP_D: w_state = IDLE;
      default: begin
        w_state     = IDLE;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
      end
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= GNT_I;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_last      <= w_last;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_i_rdata   <= w_i_rdata;
      r_d_rdata   <= w_d_rdata;
      r_i_ready   <= w_i_ready;
      r_d_ready   <= w_d_ready;
      r_busy      <= w_busy;
    end
  end

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_wd_clr),
    .i_en  (w_wd_en),
    .o_err (timeout_err)
  );

  assign i_rdata   = r_i_rdata;
  assign i_ready   = r_i_ready;
  assign d_rdata   = r_d_rdata;
  assign d_ready   = r_d_ready;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter.
// A transaction-level model predicts every output each cycle.
module tb_mem_bus_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;
  logic          timeout_err;

  mem_bus_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_ready     (i_ready),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ready     (d_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner 0 none, 1 I, 2 D; done marks the ready cycle.
  int            m_own;
  bit            m_done;
  bit            m_wr;
  bit            m_last_d;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_irdata;
  logic [DW-1:0] m_drdata;
  int            m_wait;
  bit            m_err;

  bit auto_i, auto_d, mem_hold, spur;
  int p_req;
  int mem_cnt;
  bit prev_act;
  int obs[$];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [AW-1:0] rnd_ia();
    logic [26:0] r;
    r = 27'($urandom());
    return {1'b0, r};
  endfunction

  function automatic logic [AW-1:0] rnd_da();
    logic [26:0] r;
    r = 27'($urandom());
    return {1'b1, r};
  endfunction

  task automatic model_reset();
    m_own    = 0;
    m_done   = 0;
    m_wr     = 0;
    m_last_d = 0;
    m_addr   = '0;
    m_wdata  = '0;
    m_irdata = '0;
    m_drdata = '0;
    m_wait   = 0;
    m_err    = 0;
    prev_act = 0;
  endtask

  // Advance the model across one clock edge using the sampled inputs.
  task automatic model_edge();
    bit ir, dr;
    ir = i_req;
    dr = d_read | d_write;
    if (m_own == 0) begin
      if (ir || dr) begin
        if (dr && (!ir || !m_last_d)) begin
          m_own    = 2;
          m_wr     = d_write;
          m_addr   = d_addr;
          m_wdata  = d_wdata;
          m_last_d = 1;
        end else begin
          m_own    = 1;
          m_wr     = 0;
          m_addr   = i_addr;
          m_last_d = 0;
        end
        m_done = 0;
        m_wait = 0;
      end
    end else if (!m_done) begin
      if (mem_ready) begin
        m_done = 1;
        if (!m_wr && m_own == 1) m_irdata = mem_rdata;
        if (!m_wr && m_own == 2) m_drdata = mem_rdata;
      end else begin
        m_wait++;
        if (m_wait >= TO) m_err = 1;
      end
    end else begin
      m_own  = 0;
      m_done = 0;
    end
  endtask

  task automatic check_outputs();
    bit act;
    act = (m_own != 0) && !m_done;
    check("busy", busy, m_own != 0);
    check("mem_read", mem_read, act && !m_wr);
    check("mem_write", mem_write, act && m_wr);
    if (act) check("mem_addr", mem_addr, m_addr);
    if (act && m_wr) check("mem_wdata", mem_wdata, m_wdata);
    check("i_ready", i_ready, m_done && m_own == 1);
    check("d_ready", d_ready, m_done && m_own == 2);
    check("i_rdata", i_rdata, m_irdata);
    check("d_rdata", d_rdata, m_drdata);
    check("timeout_err", timeout_err, m_err);
  endtask

  task automatic drive();
    int k;
    if (mem_ready) begin
      mem_ready = 1'b0;
    end else if ((mem_read || mem_write) && !mem_hold) begin
      if (mem_cnt == 0) begin
        mem_ready = 1'b1;
        mem_rdata = rnd128();
        mem_cnt   = $urandom_range(5, 0);
      end else begin
        mem_cnt--;
      end
    end else if (spur && !mem_read && !mem_write
                 && $urandom_range(9, 0) == 0) begin
      mem_ready = 1'b1;
      mem_rdata = rnd128();
    end
    if (i_ready) begin
      i_req = 1'b0;
    end else if (i_req) begin
      if (auto_i && $urandom_range(3, 0) == 0) i_addr = rnd_ia();
    end else if (auto_i && $urandom_range(99, 0) < p_req) begin
      i_req  = 1'b1;
      i_addr = rnd_ia();
    end
    if (d_ready) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else if (d_read || d_write) begin
      if (auto_d && $urandom_range(3, 0) == 0) begin
        d_addr  = rnd_da();
        d_wdata = rnd128();
      end
    end else if (auto_d && $urandom_range(99, 0) < p_req) begin
      k       = $urandom_range(2, 0);
      d_read  = (k != 1);
      d_write = (k != 0);
      d_addr  = rnd_da();
      d_wdata = rnd128();
    end
  endtask

  task automatic cycle();
    bit act;
    @(posedge clk);
    @(negedge clk);
    model_edge();
    check_outputs();
    act = mem_read | mem_write;
    if (act && !prev_act) obs.push_back(mem_addr[AW-1] ? 2 : 1);
    prev_act = act;
    drive();
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (!i_req && !d_read && !d_write && m_own == 0) break;
      cycle();
    end
    check("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] line;
    logic [DW-1:0] saved;
    int            exp_ord[4];
    exp_ord = '{2, 1, 2, 1};

    rst_n     = 1'b0;
    i_req     = 1'b0;
    i_addr    = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    auto_i    = 0;
    auto_d    = 0;
    mem_hold  = 1;
    spur      = 0;
    p_req     = 0;
    mem_cnt   = 0;
    model_reset();
    #2;
    check_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Lone I read, memory answers in the 4th grant cycle.
    i_req  = 1'b1;
    i_addr = 28'h0000100;
    cycle();
    check("t1_mem_read", mem_read, 1'b1);
    check("t1_mem_addr", mem_addr, 28'h0000100);
    repeat (3) cycle();
    line      = 128'hDEADBEEF_00000000_00000000_00000001;
    mem_ready = 1'b1;
    mem_rdata = line;
    cycle();
    check("t1_i_ready", i_ready, 1'b1);
    check("t1_i_rdata", i_rdata, line);
    cycle();
    check("t1_i_ready_drop", i_ready, 1'b0);
    check("t1_busy_drop", busy, 1'b0);

    // Back-to-back conflicts alternate starting with D.
    mem_hold = 0;
    auto_i   = 1;
    auto_d   = 1;
    p_req    = 100;
    obs.delete();
    for (int k = 0; k < 80; k++) begin
      if (obs.size() >= 4) break;
      cycle();
    end
    check("t2_grants", obs.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < obs.size()) check("t2_order", obs[i], exp_ord[i]);
    end
    auto_i = 0;
    auto_d = 0;
    drain();

    // Random traffic with stray mem_ready pulses.
    auto_i = 1;
    auto_d = 1;
    p_req  = 40;
    spur   = 1;
    repeat (400) cycle();
    auto_i = 0;
    auto_d = 0;
    spur   = 0;
    drain();

    // Write-back outranks read; d_rdata untouched.
    saved   = d_rdata;
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 28'h0000055;
    d_wdata = {4{32'hA5A5A5A5}};
    cycle();
    check("t4_mem_write", mem_write, 1'b1);
    check("t4_mem_read", mem_read, 1'b0);
    check("t4_mem_wdata", mem_wdata, {4{32'hA5A5A5A5}});
    for (int k = 0; k < 20; k++) begin
      if (d_ready) break;
      cycle();
    end
    check("t4_d_ready", d_ready, 1'b1);
    check("t4_d_rdata", d_rdata, saved);
    cycle();

    // Address changes after grant are ignored.
    mem_hold = 1;
    d_read   = 1'b1;
    d_addr   = 28'h0000010;
    cycle();
    d_addr = 28'h0000020;
    repeat (3) begin
      cycle();
      check("t5_mem_addr", mem_addr, 28'h0000010);
    end
    line      = rnd128();
    mem_ready = 1'b1;
    mem_rdata = line;
    cycle();
    check("t5_d_ready", d_ready, 1'b1);
    check("t5_d_rdata", d_rdata, line);
    cycle();

    // Watchdog: flag appears after TO silent grant cycles, sticks.
    i_req  = 1'b1;
    i_addr = 28'h0000300;
    cycle();
    for (int n = 1; n <= 12; n++) begin
      check("t6_wd", timeout_err, n > TO);
      cycle();
    end
    mem_ready = 1'b1;
    mem_rdata = rnd128();
    cycle();
    check("t6_i_ready", i_ready, 1'b1);
    check("t6_err_held", timeout_err, 1'b1);
    cycle();
    check("t6_err_idle", timeout_err, 1'b1);

    // Async reset in the middle of a D grant.
    d_write = 1'b1;
    d_addr  = 28'h8000077;
    d_wdata = rnd128();
    cycle();
    cycle();
    check("t7_pre_write", mem_write, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_mem_write", mem_write, 1'b0);
    check("t7_mem_read", mem_read, 1'b0);
    check("t7_busy", busy, 1'b0);
    check("t7_d_ready", d_ready, 1'b0);
    check("t7_err", timeout_err, 1'b0);
    model_reset();
    check_outputs();
    d_write = 1'b0;
    i_req   = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    mem_hold = 0;
    mem_cnt  = 2;
    obs.delete();
    i_req  = 1'b1;
    i_addr = 28'h0000400;
    d_read = 1'b1;
    d_addr = 28'h8000500;
    cycle();
    check("t7_first", obs.size() > 0 ? obs[0] : 0, 2);
    drain();
    check("t7_second", obs.size() > 1 ? obs[1] : 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
